clk_switch_ctrl: RTL and testbench
==================================

Name: clk_switch_ctrl

Overview:
- Control stage directly upstream of the CPU clock selector, clocked from C7M.
- Synchronises and debounces the speed switch SW1 and the jumpers JP2/JP3/JP4.
- Drives the one-hot DCS select vectors, the DCS bank select and the turbo enable.
- Applies changes only while the CPU bus is idle and with the CPU parked on C7M, so no selection changes while a turbo clock feeds the CPU.

Parameters:
- DB_W, 16, width of the debounce counter.
- DEBOUNCE_CYCLES, 7090, C7M cycles an input vector must stay unchanged before acceptance (~1 ms).
- IDLE_CYCLES, 2, consecutive cycles with synchronised AS_CPU_n high required before switching.
- SETTLE_CYCLES, 8, cycles held on C7M after new DCS selects are applied.

Ports:
- C7M  in  1  system clock, 7.09 MHz.
- RESET  in  1  reset, asynchronous, active-high.
- SW1  in  1  raw speed switch, asynchronous; 1 = stock C7M, 0 = turbo.
- JP2  in  1  jumper, code bit 2 (MSB), asynchronous.
- JP3  in  1  jumper, code bit 1.
- JP4  in  1  jumper, code bit 0.
- AS_CPU_n  in  1  CPU address strobe, asynchronous to C7M.
- CLKSEL0  out  4  one-hot select for DCS bank 0 (C7M/C14M/C21M/C28M).
- CLKSEL1  out  4  one-hot select for DCS bank 1 (C33M/C42M/C50M/OSC_CLK).
- BANK_SEL  out  1  0 = bank 0 output, 1 = bank 1 output.
- TURBO_EN  out  1  1 = CPU on selected turbo clock, 0 = CPU on C7M.
- BUSY  out  1  a switch is pending or in progress.

Behaviour:
- Reset (asynchronous, immediate):
  - CLKSEL0=0001, CLKSEL1=0001, BANK_SEL=0, TURBO_EN=0, BUSY=0, FSM=IDLE.
  - Accepted vector {sw,code}=4'b1_000; applied state {turbo=0, code=000}; all counters=0.
  - Reset mid-switch abandons the switch. TURBO_EN drops asynchronously.
- Synchronisers:
  - Two-flop synchroniser on each of SW1, JP2, JP3, JP4, AS_CPU_n.
  - The sampled vector is V={SW1,JP2,JP3,JP4}.
- Debounce:
  - If V ≠ last sample, the counter clears.
  - Otherwise the counter increments, saturating.
  - When the counter reaches DEBOUNCE_CYCLES-1 with V unchanged, the accepted vector is loaded with V.
  - Any single-bit glitch restarts the count.
- Target: turbo_t = !accepted.sw; code_t = accepted.code.
- FSM:
  - IDLE: if {turbo_t,code_t} ≠ applied, go to WAIT_BUS and set BUSY=1.
  - WAIT_BUS:
    - idle_cnt increments while synced AS_CPU_n=1 and clears when it is 0.
    - At idle_cnt=IDLE_CYCLES, go to PARK.
    - If the target returns to equal applied, go to IDLE with BUSY=0 and outputs unchanged.
  - PARK (1 cycle): TURBO_EN<=0; go to SELECT.
  - SELECT (1 cycle):
    - Target is latched into applied.
    - code_t[2]=0: CLKSEL0<=onehot(code_t[1:0]); CLKSEL1 holds.
    - code_t[2]=1: CLKSEL1<=onehot(code_t[1:0]); CLKSEL0 holds.
    - BANK_SEL<=code_t[2]. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then TURBO_EN<=applied.turbo, BUSY<=0, go to IDLE.
- Stability rules:
  - Target changes after SELECT are ignored until IDLE; they are re-evaluated there.
  - CLKSEL0, CLKSEL1 and BANK_SEL change only in SELECT, i.e. only with TURBO_EN=0 for ≥1 prior cycle.
  - TURBO_EN rises only at the end of SETTLE.
- A turbo-off request (SW1 0→1) follows the same path and ends with TURBO_EN=0. Selects still update to the jumper code.
- Latency, input edge to TURBO_EN rise with bus idle: 2 (sync) + DEBOUNCE_CYCLES + IDLE_CYCLES + 2 + SETTLE_CYCLES cycles, ±1.
- onehot(n) = 4'b0001<<n.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, IDLE_CYCLES=2, SETTLE_CYCLES=4.
- Reset release with SW1=1, JP=000, AS_CPU_n=1 -> outputs hold reset values; BUSY never asserts.
- SW1→0, JP=011, AS_CPU_n=1:
  - BUSY asserts about 10 cycles after the edge.
  - Then CLKSEL0=1000, BANK_SEL=0, CLKSEL1=0001.
  - TURBO_EN=1 four cycles after SELECT; BUSY=0.
- From C28M turbo, JP→110 with AS_CPU_n held 0:
  - FSM stays in WAIT_BUS; TURBO_EN stays 1; selects unchanged.
  - AS_CPU_n→1 -> TURBO_EN=0, then CLKSEL1=0100, BANK_SEL=1, CLKSEL0=1000 held, TURBO_EN=1 after settle.
- SW1 pulses 0 for 5 cycles, then back to 1 -> no acceptance; BUSY stays 0; outputs unchanged.
- JP toggles 000→101→000 within WAIT_BUS (AS_CPU_n=0) -> FSM returns to IDLE; BUSY=0; no select change.
- RESET asserted in SETTLE -> TURBO_EN=0 and CLKSEL0/CLKSEL1=0001 immediately. After release, a stable SW1=0 restarts a full switch.

Source files
------------

// File: rtl/clk_switch_ctrl_if.sv
// Signal bundle between the CPU clock-switch controller and its surroundings:
// raw switch/jumper/strobe inputs and the DCS select / turbo outputs.
interface clk_switch_ctrl_if;
  logic       SW1;
  logic       JP2;
  logic       JP3;
  logic       JP4;
  logic       AS_CPU_n;
  logic [3:0] CLKSEL0;
  logic [3:0] CLKSEL1;
  logic       BANK_SEL;
  logic       TURBO_EN;
  logic       BUSY;

  modport master (
    output SW1, JP2, JP3, JP4, AS_CPU_n,
    input  CLKSEL0, CLKSEL1, BANK_SEL, TURBO_EN, BUSY
  );

  modport slave (
    input  SW1, JP2, JP3, JP4, AS_CPU_n,
    output CLKSEL0, CLKSEL1, BANK_SEL, TURBO_EN, BUSY
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// CPU clock-switch controller: synchronises and debounces SW1/JP2-4, then applies
// a new DCS selection only while the bus is idle and the CPU is parked on C7M.
module clk_switch_ctrl #(
  parameter int DB_W            = 16,
  parameter int DEBOUNCE_CYCLES = 7090,
  parameter int IDLE_CYCLES     = 2,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic              C7M,
  input  logic              RESET,
  clk_switch_ctrl_if.slave  bus
);

  localparam int IC_W = $clog2(IDLE_CYCLES + 1);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_PRE  = DB_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_PARK, S_SELECT, S_SETTLE
  } state_e;

  typedef struct packed {
    logic       turbo;
    logic [2:0] code;
  } sel_t;

  // Synchronisers: bits are {SW1, JP2, JP3, JP4, AS_CPU_n}.
  logic [4:0] sync1_q, sync2_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, whatever the statement order.
  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 5'b1_000_1;
      sync2_q <= 5'b1_000_1;
    end else begin
      sync1_q <= {bus.SW1, bus.JP2, bus.JP3, bus.JP4, bus.AS_CPU_n};
      sync2_q <= sync1_q;
    end
  end

  logic [3:0] vec_s;
  logic       bus_idle_s;
  assign vec_s      = sync2_q[4:1];
  assign bus_idle_s = sync2_q[0];

  logic [3:0]      last_q, acc_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      last_q   <= 4'b1_000;
      acc_q    <= 4'b1_000;
      db_cnt_q <= '0;
    end else begin
      last_q <= vec_s;
      if (vec_s != last_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q != DB_LAST) begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      // Accept on the edge where the run length reaches DEBOUNCE_CYCLES-1.
      if (vec_s == last_q && db_cnt_q == DB_PRE) begin
        acc_q <= vec_s;
      end
    end
  end

  sel_t target;
  assign target = '{turbo: ~acc_q[3], code: acc_q[2:0]};

  state_e          state_q, state_d;
  sel_t            applied_q, applied_d;
  logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [SC_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [3:0]      clksel0_q, clksel0_d, clksel1_q, clksel1_d;
  logic            bank_q, bank_d, turbo_q, turbo_d, busy_q, busy_d;

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (target != applied_q) state_d = S_WAIT_BUS;
      S_WAIT_BUS: begin
        if (target == applied_q) begin
          state_d = S_IDLE;
        end else if (bus_idle_s && idle_cnt_q == IC_W'(IDLE_CYCLES - 1)) begin
          state_d = S_PARK;
        end
      end
      S_PARK:     state_d = S_SELECT;
      S_SELECT:   state_d = S_SETTLE;
      S_SETTLE:   if (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    applied_d    = applied_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    clksel0_d    = clksel0_q;
    clksel1_d    = clksel1_q;
    bank_d       = bank_q;
    turbo_d      = turbo_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (target != applied_q) busy_d = 1'b1;
      end
      S_WAIT_BUS: begin
        idle_cnt_d = bus_idle_s ? idle_cnt_q + 1'b1 : '0;
        if (target == applied_q) busy_d = 1'b0;
      end
      S_PARK: turbo_d = 1'b0;
      S_SELECT: begin
        // Only the addressed bank's select moves; the other DCS keeps its clock.
        applied_d    = target;
        settle_cnt_d = '0;
        bank_d       = target.code[2];
        if (target.code[2]) clksel1_d = 4'b0001 << target.code[1:0];
        else                clksel0_d = 4'b0001 << target.code[1:0];
      end
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
          turbo_d = applied_q.turbo;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      applied_q    <= '{turbo: 1'b0, code: 3'b000};
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
      clksel0_q    <= 4'b0001;
      clksel1_q    <= 4'b0001;
      bank_q       <= 1'b0;
      turbo_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      applied_q    <= applied_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      clksel0_q    <= clksel0_d;
      clksel1_q    <= clksel1_d;
      bank_q       <= bank_d;
      turbo_q      <= turbo_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.CLKSEL0  = clksel0_q;
  assign bus.CLKSEL1  = clksel1_q;
  assign bus.BANK_SEL = bank_q;
  assign bus.TURBO_EN = turbo_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl: expected selects are queued per switch
// request and compared when BUSY falls; a monitor also checks ordering rules.
module tb_clk_switch_ctrl;

  localparam int DEB = 8;
  localparam int IDL = 2;
  localparam int SET = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_switch_ctrl_if bus ();

  clk_switch_ctrl #(
    .DB_W(16), .DEBOUNCE_CYCLES(DEB), .IDLE_CYCLES(IDL), .SETTLE_CYCLES(SET)
  ) dut (
    .C7M(clk), .RESET(rst), .bus(bus)
  );

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
    logic       bank;
    logic       turbo;
  } out_t;

  out_t sb_q[$];
  out_t sb_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic sw, input logic [2:0] jp, input logic as_n);
    bus.SW1      = sw;
    bus.JP2      = jp[2];
    bus.JP3      = jp[1];
    bus.JP4      = jp[0];
    bus.AS_CPU_n = as_n;
  endtask

  task automatic wait_busy(input logic val, input int max, input string tag);
    int n = 0;
    while (bus.BUSY !== val && n < max) begin
      cycles(1);
      n++;
    end
    check(tag, bus.BUSY, val);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                            input logic bank, input logic turbo, input logic busy);
    check({tag, "_clksel0"}, bus.CLKSEL0, s0);
    check({tag, "_clksel1"}, bus.CLKSEL1, s1);
    check({tag, "_bank"},    bus.BANK_SEL, bank);
    check({tag, "_turbo"},   bus.TURBO_EN, turbo);
    check({tag, "_busy"},    bus.BUSY, busy);
  endtask

  // Monitor: select changes need TURBO_EN low before and during; TURBO_EN rises
  // SET cycles after the select change; each BUSY fall retires one scoreboard entry.
  logic [3:0] p_s0 = 4'b0001, p_s1 = 4'b0001;
  logic       p_bank = 1'b0, p_turbo = 1'b0, p_busy = 1'b0;
  int         cyc = 0, sel_cyc = 0, sel_changes = 0;
  bit         busy_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (bus.BUSY) busy_seen = 1'b1;
      if ({bus.CLKSEL0, bus.CLKSEL1, bus.BANK_SEL} != {p_s0, p_s1, p_bank}) begin
        sel_changes++;
        sel_cyc = cyc;
        check("sel_chg_turbo_prev", p_turbo, 1'b0);
        check("sel_chg_turbo_now", bus.TURBO_EN, 1'b0);
      end
      if (!p_turbo && bus.TURBO_EN) check("turbo_rise_delay", cyc - sel_cyc, SET);
      if (p_busy && !bus.BUSY) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_clksel0", bus.CLKSEL0, sb_e.s0);
          check("sb_clksel1", bus.CLKSEL1, sb_e.s1);
          check("sb_bank", bus.BANK_SEL, sb_e.bank);
          check("sb_turbo", bus.TURBO_EN, sb_e.turbo);
        end
      end
    end
    p_s0    = bus.CLKSEL0;
    p_s1    = bus.CLKSEL1;
    p_bank  = bus.BANK_SEL;
    p_turbo = bus.TURBO_EN;
    p_busy  = bus.BUSY;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sc;
    rst = 1'b1;
    set_in(1'b1, 3'b000, 1'b1);
    cycles(3);
    check_outs("reset", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Stock setting after reset: nothing to do.
    busy_seen = 1'b0;
    cycles(30);
    check("idle_busy_seen", busy_seen, 1'b0);
    check_outs("idle", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);

    // Turbo on, C28M.
    set_in(1'b0, 3'b011, 1'b1);
    sb_q.push_back('{4'b1000, 4'b0001, 1'b0, 1'b1});
    n = 0;
    while (!bus.BUSY && n < 40) begin
      cycles(1);
      n++;
    end
    check($sformatf("c28_busy_latency_%0d_in_10_14", n), (n >= 10 && n <= 14), 1'b1);
    wait_busy(1'b0, 60, "c28_busy_done");

    // Jumper change to bank 1 while the bus stays busy.
    set_in(1'b0, 3'b011, 1'b0);
    cycles(4);
    set_in(1'b0, 3'b110, 1'b0);
    sb_q.push_back('{4'b1000, 4'b0100, 1'b1, 1'b1});
    cycles(30);
    check_outs("bus_held", 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 3'b110, 1'b1);
    wait_busy(1'b0, 60, "bank1_busy_done");

    // Turbo off: selects follow the jumpers, TURBO_EN ends low.
    set_in(1'b1, 3'b110, 1'b1);
    sb_q.push_back('{4'b1000, 4'b0100, 1'b1, 1'b0});
    wait_busy(1'b1, 40, "off_busy_start");
    wait_busy(1'b0, 60, "off_busy_done");

    // Short SW1 glitch is rejected.
    busy_seen = 1'b0;
    sc = sel_changes;
    set_in(1'b0, 3'b110, 1'b1);
    cycles(5);
    set_in(1'b1, 3'b110, 1'b1);
    cycles(30);
    check("glitch_busy_seen", busy_seen, 1'b0);
    check("glitch_sel_changes", sel_changes, sc);
    check("glitch_turbo", bus.TURBO_EN, 1'b0);

    // Back to code 000 with turbo off.
    set_in(1'b1, 3'b000, 1'b1);
    sb_q.push_back('{4'b0001, 4'b0100, 1'b0, 1'b0});
    wait_busy(1'b1, 40, "jp000_busy_start");
    wait_busy(1'b0, 60, "jp000_busy_done");

    // Request withdrawn while waiting for the bus.
    set_in(1'b1, 3'b000, 1'b0);
    cycles(4);
    sc = sel_changes;
    set_in(1'b1, 3'b101, 1'b0);
    sb_q.push_back('{4'b0001, 4'b0100, 1'b0, 1'b0});
    wait_busy(1'b1, 40, "abort_busy_start");
    set_in(1'b1, 3'b000, 1'b0);
    wait_busy(1'b0, 60, "abort_busy_done");
    set_in(1'b1, 3'b000, 1'b1);
    cycles(20);
    check("abort_sel_changes", sel_changes, sc);
    check("abort_busy_after", bus.BUSY, 1'b0);

    // Reset during SETTLE, then a clean restart.
    check("pre_reset_sb_empty", sb_q.size(), 0);
    set_in(1'b0, 3'b001, 1'b1);
    n = 0;
    while (bus.CLKSEL0 !== 4'b0010 && n < 40) begin
      cycles(1);
      n++;
    end
    check("settle_sel_seen", bus.CLKSEL0, 4'b0010);
    cycles(1);
    #1;
    rst = 1'b1;
    #1;
    check_outs("mid_reset", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    cycles(2);
    rst = 1'b0;
    sb_q.push_back('{4'b0010, 4'b0001, 1'b0, 1'b1});
    wait_busy(1'b1, 40, "restart_busy_start");
    wait_busy(1'b0, 60, "restart_busy_done");

    cycles(5);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
